// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational datapath ALU: accepts an op over valid/ready, drives the
// registered ALU operands, waits SETTLE edges, then returns BusW/Zero over valid/ready.
module alu_op_sequencer #(
    parameter int unsigned N      = 64,
    parameter int unsigned SETTLE = 2
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic [N-1:0] alu_busa,
    output logic [N-1:0] alu_busb,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_busw,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_illegal
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    stateT         state;
    stateT         stateNext;
    logic [CW-1:0] cnt;
    logic          opLegal;
    logic          acceptLegal;
    logic          acceptIllegal;
    logic          capture;

    always_comb begin
        opLegal = 1'b0;
        case (req_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: opLegal = 1'b1;
            default:                                     opLegal = 1'b0;
        endcase
    end

    always_comb begin
        stateNext     = state;
        acceptLegal   = 1'b0;
        acceptIllegal = 1'b0;
        capture       = 1'b0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (opLegal) begin
                        acceptLegal = 1'b1;
                        stateNext   = WAIT;
                    end else begin
                        acceptIllegal = 1'b1;
                        stateNext     = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= stateNext;
    end

    // ALU drive registers only move on a legal accept so the ALU sees stable inputs between ops
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            alu_busa    <= '0;
            alu_busb    <= '0;
            alu_ctrl    <= '0;
            cnt         <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            if (acceptLegal) begin
                alu_busa <= req_a;
                alu_busb <= req_b;
                alu_ctrl <= req_op;
                cnt      <= CNT_INIT;
            end else if (state == WAIT && !capture) begin
                cnt <= cnt - CW'(1);
            end
            if (acceptIllegal) begin
                rsp_result  <= '0;
                rsp_zero    <= 1'b1;
                rsp_illegal <= 1'b1;
            end else if (capture) begin
                rsp_result  <= alu_busw;
                rsp_zero    <= alu_zero;
                rsp_illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: emulates a settling ALU, keeps a timing/result scoreboard model,
// and runs directed vectors with literal expectations.
module tb_alu_op_sequencer;

    localparam int unsigned N      = 64;
    localparam int unsigned SETTLE = 2;

    logic         CLK       = 1'b0;
    logic         RESETn    = 1'b0;
    logic         req_valid = 1'b0;
    logic         rsp_ready = 1'b1;
    logic [3:0]   req_op    = 4'b0000;
    logic [N-1:0] req_a     = '0;
    logic [N-1:0] req_b     = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic         rsp_zero;
    logic         rsp_illegal;
    logic         alu_zero;
    logic [N-1:0] alu_busa;
    logic [N-1:0] alu_busb;
    logic [N-1:0] alu_busw;
    logic [N-1:0] rsp_result;
    logic [3:0]   alu_ctrl;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    alu_op_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_ctrl(alu_ctrl),
        .alu_busw(alu_busw), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [N-1:0] aluRef(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return '0;
        endcase
    endfunction

    function automatic bit isLegal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    endfunction

    // ALU stand-in whose output lags its inputs by one edge, so an early capture sees stale data
    logic [N-1:0] aluW = '0;
    always @(posedge CLK) aluW <= aluRef(alu_ctrl, alu_busa, alu_busb);
    assign alu_busw = aluW;
    assign alu_zero = (aluW == '0);

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: one outstanding op, response visible once cyc reaches mDue
    bit           mBusy = 1'b0;
    int unsigned  mDue  = 0;
    logic [N-1:0] mRes  = '0;
    logic         mZero = 1'b0;
    logic         mIll  = 1'b0;
    logic [N-1:0] mA    = '0;
    logic [N-1:0] mB    = '0;
    logic [3:0]   mC    = 4'b0000;

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            mBusy <= 1'b0; mDue <= 0; mRes <= '0; mZero <= 1'b0; mIll <= 1'b0;
            mA <= '0; mB <= '0; mC <= 4'b0000;
        end else if (mBusy) begin
            if (cyc >= mDue && rsp_ready) mBusy <= 1'b0;
        end else if (req_valid) begin
            mBusy <= 1'b1;
            if (isLegal(req_op)) begin
                mA    <= req_a;
                mB    <= req_b;
                mC    <= req_op;
                mDue  <= cyc + 1 + SETTLE;
                mRes  <= aluRef(req_op, req_a, req_b);
                mZero <= (aluRef(req_op, req_a, req_b) == '0);
                mIll  <= 1'b0;
            end else begin
                mDue  <= cyc + 1;
                mRes  <= '0;
                mZero <= 1'b1;
                mIll  <= 1'b1;
            end
        end
    end

    bit expValid;
    always @(negedge CLK) begin
        expValid = mBusy && (cyc >= mDue);
        check("req_ready", N'(req_ready), N'(!mBusy));
        check("rsp_valid", N'(rsp_valid), N'(expValid));
        check("alu_busa", alu_busa, mA);
        check("alu_busb", alu_busb, mB);
        check("alu_ctrl", N'(alu_ctrl), N'(mC));
        if (!RESETn || expValid) begin
            check("rsp_result", rsp_result, mRes);
            check("rsp_zero", N'(rsp_zero), N'(mZero));
            check("rsp_illegal", N'(rsp_illegal), N'(mIll));
        end
    end

    logic [N-1:0] rspLog[$];
    always @(negedge CLK) if (rsp_valid && rsp_ready) rspLog.push_back(rsp_result);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold, output int unsigned accEdge);
        int unsigned n;
        n = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check("acceptTimeout", N'(req_ready), N'(1));
        accEdge = cyc + 1;
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitRsp(output int unsigned validEdge);
        int unsigned n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("rspTimeout", N'(rsp_valid), N'(1));
        validEdge = cyc;
    endtask

    initial begin
        int unsigned acc, acc2, vld;

        tick();
        tick();
        check("rstReady", N'(req_ready), N'(1));
        check("rstValid", N'(rsp_valid), N'(0));
        check("rstCtrl", N'(alu_ctrl), N'(0));
        check("rstBusA", alu_busa, '0);
        RESETn = 1'b1;
        tick();

        issue(4'b0010, 64'd5, 64'd7, 1'b0, acc);
        check("addCtrl", N'(alu_ctrl), N'(4'b0010));
        waitRsp(vld);
        check("addLatency", N'(vld - acc), N'(SETTLE));
        check("addResult", rsp_result, 64'd12);
        check("addZero", N'(rsp_zero), N'(0));
        check("addIllegal", N'(rsp_illegal), N'(0));
        tick();

        issue(4'b0110, 64'h10, 64'h10, 1'b0, acc);
        waitRsp(vld);
        check("subResult", rsp_result, 64'd0);
        check("subZero", N'(rsp_zero), N'(1));
        tick();

        issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, acc);
        waitRsp(vld);
        check("wrapResult", rsp_result, 64'd0);
        check("wrapZero", N'(rsp_zero), N'(1));
        tick();

        // illegal op: response already valid in the cycle right after the accept edge
        issue(4'b1111, 64'h1234, 64'h5678, 1'b0, acc);
        waitRsp(vld);
        check("illLatency", N'(vld - acc), N'(0));
        check("illFlag", N'(rsp_illegal), N'(1));
        check("illResult", rsp_result, 64'd0);
        check("illZero", N'(rsp_zero), N'(1));
        check("illCtrlHeld", N'(alu_ctrl), N'(4'b0010));
        check("illBusAHeld", alu_busa, 64'hFFFF_FFFF_FFFF_FFFF);
        check("illBusBHeld", alu_busb, 64'd1);
        tick();

        rsp_ready = 1'b0;
        issue(4'b0111, 64'h55, 64'hAB, 1'b0, acc);
        waitRsp(vld);
        for (int i = 0; i < 5; i++) begin
            check("bpResult", rsp_result, 64'hAB);
            check("bpValid", N'(rsp_valid), N'(1));
            check("bpReqReady", N'(req_ready), N'(0));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bpIdle", N'(req_ready), N'(1));
        check("bpValidLow", N'(rsp_valid), N'(0));

        rspLog.delete();
        issue(4'b0000, 64'hF0, 64'h3C, 1'b1, acc);
        issue(4'b0001, 64'hF0, 64'h3C, 1'b0, acc2);
        check("b2bInterval", N'(acc2 - acc), N'(SETTLE + 2));
        waitRsp(vld);
        tick();
        tick();
        check("b2bCount", N'(rspLog.size()), N'(2));
        if (rspLog.size() == 2) begin
            check("b2bAnd", rspLog[0], 64'h30);
            check("b2bOr", rspLog[1], 64'hFC);
        end

        issue(4'b0010, 64'd3, 64'd4, 1'b0, acc);
        #2;
        RESETn = 1'b0;
        #1;
        check("midRstReady", N'(req_ready), N'(1));
        check("midRstValid", N'(rsp_valid), N'(0));
        check("midRstCtrl", N'(alu_ctrl), N'(0));
        check("midRstBusA", alu_busa, '0);
        check("midRstBusB", alu_busb, '0);
        check("midRstResult", rsp_result, '0);
        tick();
        tick();
        RESETn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("noStaleRsp", N'(rsp_valid), N'(0));
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
